// File: rtl/ring_seq_pkg.sv
// Shared types, mode constants and seed helper for the ring_sequencer block.
// Seeds are built at SEED_MAX_W bits and truncated to the instance width by the caller.
package ring_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;

  localparam int SEED_MAX_W = 64;

  // Ring seeds put the single hot bit at the MSB; Johnson starts from all zeros.
  function automatic logic [SEED_MAX_W-1:0] seed(input logic m, input int width);
    logic [SEED_MAX_W-1:0] s;
    s = '0;
    if (m == MODE_RING) begin
      s = SEED_MAX_W'(1) << (width - 1);
    end
    return s;
  endfunction

endpackage

// File: rtl/ring_seq_shift.sv
// Combinational next-pattern generator for ring/Johnson rotation in either direction.
// The legality checker only exists when RING_SEQ_SELFCORRECT_EN is defined.
module ring_seq_shift
  import ring_seq_pkg::*;
#(
  parameter int WIDTH = 15
) (
  input  logic [WIDTH-1:0] pat_i,
  input  logic             mode_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] next_o
`ifdef RING_SEQ_SELFCORRECT_EN
  ,
  output logic             legal_o
`endif
);

  logic fb;

  always_comb begin
    fb = dir_i ? pat_i[0] : pat_i[WIDTH-1];
    if (mode_i == MODE_JOHNSON) begin
      fb = ~fb;
    end
    next_o = dir_i ? {fb, pat_i[WIDTH-1:1]} : {pat_i[WIDTH-2:0], fb};
  end

`ifdef RING_SEQ_SELFCORRECT_EN
  logic [WIDTH-1:0] rotated;

  // A legal Johnson pattern is one contiguous run of ones around the ring: at most one 1->0 edge.
  always_comb begin
    rotated = {pat_i[0], pat_i[WIDTH-1:1]};
    if (mode_i == MODE_JOHNSON) begin
      legal_o = ($countones(pat_i & ~rotated) <= 1);
    end else begin
      legal_o = ($countones(pat_i) == 1);
    end
  end
`endif

endmodule

// File: rtl/ring_sequencer.sv
// Run-length controlled ring/Johnson pattern sequencer with start/stop FSM and status pulses.
// Define RING_SEQ_SELFCORRECT_EN to replace illegal patterns with the seed and pulse err.
module ring_sequencer
  import ring_seq_pkg::*;
#(
  parameter int WIDTH = 15,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             mode,
  input  logic [CNTW-1:0]  steps,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic             err
);

  localparam logic [WIDTH-1:0] RING_SEED    = WIDTH'(seed(MODE_RING, WIDTH));
  localparam logic [WIDTH-1:0] JOHNSON_SEED = WIDTH'(seed(MODE_JOHNSON, WIDTH));

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CNTW-1:0]  rem_q, rem_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] shiftNext;
  logic [WIDTH-1:0] latchedSeed;

  assign latchedSeed = (mode_q == MODE_JOHNSON) ? JOHNSON_SEED : RING_SEED;

`ifdef RING_SEQ_SELFCORRECT_EN
  logic legal;
  logic err_q, err_d;

  ring_seq_shift #(.WIDTH(WIDTH)) u_shift (
    .pat_i   (out_q),
    .mode_i  (mode_q),
    .dir_i   (dir),
    .next_o  (shiftNext),
    .legal_o (legal)
  );
`else
  ring_seq_shift #(.WIDTH(WIDTH)) u_shift (
    .pat_i  (out_q),
    .mode_i (mode_q),
    .dir_i  (dir),
    .next_o (shiftNext)
  );
`endif

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    out_d   = out_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
`ifdef RING_SEQ_SELFCORRECT_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
          mode_d  = mode;
          rem_d   = steps;
          if (mode != mode_q) begin
            out_d = (mode == MODE_JOHNSON) ? JOHNSON_SEED : RING_SEED;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else begin
`ifdef RING_SEQ_SELFCORRECT_EN
          if (legal) begin
            out_d = shiftNext;
          end else begin
            out_d = latchedSeed;
            err_d = 1'b1;
          end
`else
          out_d = shiftNext;
`endif
          wrap_d = (out_d == latchedSeed);
          // rem==0 means free-run, so only counted runs decrement and can finish.
          if (rem_q != '0) begin
            rem_d = rem_q - CNTW'(1);
            if (rem_q == CNTW'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_RING;
      out_q   <= RING_SEED;
      rem_q   <= '0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
`ifdef RING_SEQ_SELFCORRECT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
`ifdef RING_SEQ_SELFCORRECT_EN
      err_q   <= err_d;
`endif
    end
  end

  assign out  = out_q;
  assign busy = (state_q == RUN);
  assign done = done_q;
  assign wrap = wrap_q;
`ifdef RING_SEQ_SELFCORRECT_EN
  assign err  = err_q;
`else
  assign err  = 1'b0;
`endif

endmodule
